// File: rtl/cbus_arbiter.sv
// cbus_arbiter: N-to-1 CBus arbiter; the grant is held for a whole burst, until ready && last.
// Define CBUS_ARB_RR_EN for round-robin arbitration; otherwise the lowest index wins.
package cbus_pkg;
    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [7:0]  strobe;
        logic [63:0] data;
        logic [7:0]  len;
        logic [1:0]  burst;
    } cbus_req_t;
    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;
endpackage

module cbus_arbiter
    import cbus_pkg::*;
#(
    parameter int NUM_REQ = 2,
    localparam int IDX_W = $clog2(NUM_REQ)
) (
    input  logic             clk,
    input  logic             reset,
    input  cbus_req_t        ireqs [NUM_REQ],
    output cbus_resp_t       iresps [NUM_REQ],
    output cbus_req_t        oreq,
    input  cbus_resp_t       oresp,
    output logic             busy,
    output logic [IDX_W-1:0] grant_idx
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t state, state_n;
    logic [IDX_W-1:0] base, winner;
    logic any_valid, done;
`ifdef CBUS_ARB_RR_EN
    logic [IDX_W-1:0] rr_ptr;
    always_ff @(posedge clk)
        if (reset) rr_ptr <= '0;
        else if (state == IDLE && any_valid) rr_ptr <= IDX_W'((int'(winner) + 1) % NUM_REQ);
    assign base = rr_ptr;
`else
    assign base = '0;
`endif
    // scan downward from base so the final hit is the requester nearest to base
    always_comb begin
        winner = '0;
        any_valid = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (ireqs[(int'(base) + k) % NUM_REQ].valid) begin
                winner = IDX_W'((int'(base) + k) % NUM_REQ);
                any_valid = 1'b1;
            end
    end
    assign done = (oresp.ready && oresp.last) || !ireqs[grant_idx].valid;
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            grant_idx <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && any_valid) grant_idx <= winner;
        end
    end
    always_comb begin
        state_n = (state == IDLE) ? (any_valid ? BUSY : IDLE) : (done ? IDLE : BUSY);
        busy = state == BUSY;
        oreq = busy ? ireqs[grant_idx] : '0;
        for (int i = 0; i < NUM_REQ; i++)
            iresps[i] = (busy && grant_idx == IDX_W'(i)) ? oresp : '0;
    end
endmodule

// File: tb/tb_cbus_arbiter.sv
// tb_cbus_arbiter: directed stimulus, a transaction-level ownership model and a simple
// zero-delay bridge responder; works with or without CBUS_ARB_RR_EN.
module tb_cbus_arbiter;
    import cbus_pkg::*;
    logic       clk = 0, reset = 1;
    cbus_req_t  ireqs [2];
    cbus_resp_t iresps [2];
    cbus_req_t  oreq;
    cbus_resp_t oresp;
    logic       busy;
    logic [0:0] grant_idx;
    int tests = 0, fails = 0, cyc = 0, beat = 0, nb, n, c0;
    int owner = -1, last_gnt = 0, rr = 0;
    int seq [6];
    bit armed = 0, ok, pb;

    cbus_arbiter #(.NUM_REQ(2)) dut (
        .clk(clk), .reset(reset), .ireqs(ireqs), .iresps(iresps),
        .oreq(oreq), .oresp(oresp), .busy(busy), .grant_idx(grant_idx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
        end
    endfunction

    // first valid requester, scanning from the round-robin start point when enabled
    function automatic int pick();
        int s = 0;
`ifdef CBUS_ARB_RR_EN
        s = rr;
`endif
        for (int k = 0; k < 2; k++)
            if (ireqs[(s + k) % 2].valid) return (s + k) % 2;
        return -1;
    endfunction

    // ownership model: who holds the bus, who was granted last
    always @(posedge clk) begin
        if (reset) begin
            owner <= -1;
            last_gnt <= 0;
            rr <= 0;
            armed <= 1;
        end else if (owner < 0) begin
            if (pick() >= 0) begin
                owner <= pick();
                last_gnt <= pick();
                rr <= (pick() + 1) % 2;
            end
        end else if ((oresp.ready && oresp.last) || !ireqs[owner].valid) owner <= -1;
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("m_busy", busy, owner >= 0);
            chk("m_grant", grant_idx, last_gnt);
            chk("m_oreq", oreq, owner >= 0 ? ireqs[owner < 0 ? 0 : owner] : '0);
            for (int i = 0; i < 2; i++)
                chk("m_iresp", iresps[i], owner == i ? oresp : '0);
        end
    end

    // bridge: one ready beat per cycle while valid, last on beat len
    initial begin
        oresp = '0;
        forever begin
            @(posedge clk);
            #2;
            if (!oreq.valid || (oresp.ready && oresp.last)) beat = 0;
            else if (oresp.ready) beat++;
            oresp.ready = oreq.valid;
            oresp.last = oreq.valid && beat == int'(oreq.len);
            oresp.data = {32'hA5A5_0000 + 32'(beat), oreq.addr};
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // counts ready beats of port p from the current cycle until its last beat
    task automatic wait_last(input int p);
        nb = 0;
        ok = 0;
        for (int t = 0; t < 40 && !ok; t++) begin
            if (iresps[p].ready) nb++;
            if (iresps[p].ready && iresps[p].last) ok = 1;
            else @(negedge clk);
        end
        chk("last_seen", ok, 1);
    endtask

    task automatic wait_grant(input int p);
        ok = 0;
        for (int t = 0; t < 40 && !ok; t++) begin
            @(negedge clk);
            if (busy && grant_idx == 1'(p)) ok = 1;
        end
        chk("grant_seen", ok, 1);
    endtask

    initial begin
        ireqs[0] = '0;
        ireqs[1] = '0;
        repeat (2) step();
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant_idx, 0);
        chk("rst_oreq", oreq, 0);
        step();
        reset = 0;

        // single requester, 4-beat INCR read
        step();
        ireqs[1] = '{valid: 1, is_write: 0, size: 3, addr: 32'h8000_0000, strobe: 8'hFF, data: 0, len: 3, burst: 1};
        @(negedge clk);
        chk("t1_arb_busy", busy, 0);
        @(negedge clk);
        chk("t1_grant", grant_idx, 1);
        chk("t1_busy", busy, 1);
        chk("t1_addr", oreq.addr, 32'h8000_0000);
        chk("t1_p0_zero", iresps[0], 0);
        wait_last(1);
        chk("t1_beats", nb, 4);
        step();
        ireqs[1] = '0;
        @(negedge clk);
        chk("t1_busy_drop", busy, 0);

        // contention: port 0 first, port 1 two cycles after port 0's last
        step();
        ireqs[0] = '{valid: 1, is_write: 0, size: 3, addr: 32'h100, strobe: 8'hFF, data: 0, len: 1, burst: 1};
        ireqs[1] = '{valid: 1, is_write: 0, size: 3, addr: 32'h180, strobe: 8'hFF, data: 0, len: 0, burst: 0};
        @(negedge clk);
        @(negedge clk);
        chk("t2_first", grant_idx, 0);
        wait_last(0);
        chk("t2_beats", nb, 2);
        c0 = cyc;
        step();
        ireqs[0] = '0;
        wait_grant(1);
        chk("t2_gap", cyc - c0, 2);
        wait_last(1);
        step();
        ireqs[1] = '0;
        @(negedge clk);

        // continuous 1-beat writes from both ports, six grants
        step();
        ireqs[0] = '{valid: 1, is_write: 1, size: 3, addr: 32'h200, strobe: 8'hFF, data: 64'h11, len: 0, burst: 0};
        ireqs[1] = '{valid: 1, is_write: 1, size: 3, addr: 32'h300, strobe: 8'hFF, data: 64'h22, len: 0, burst: 0};
        n = 0;
        pb = 0;
        for (int t = 0; t < 60 && n < 6; t++) begin
            @(negedge clk);
            if (busy && !pb) begin
                seq[n] = int'(grant_idx);
                n++;
            end
            pb = busy;
        end
        chk("t3_count", n, 6);
        for (int k = 0; k < 6; k++)
`ifdef CBUS_ARB_RR_EN
            chk("t3_seq", seq[k], k % 2);
`else
            chk("t3_seq", seq[k], 0);
`endif
        step();
        ireqs[0] = '0;
        ireqs[1] = '0;
        @(negedge clk);

        // write pass-through
        step();
        ireqs[0] = '{valid: 1, is_write: 1, size: 3, addr: 32'h8000_0010, strobe: 8'h0F,
                     data: 64'hDEAD_BEEF_CAFE_BABE, len: 0, burst: 0};
        @(negedge clk);
        @(negedge clk);
        chk("t4_busy", busy, 1);
        chk("t4_wr", oreq.is_write, 1);
        chk("t4_addr", oreq.addr, 32'h8000_0010);
        chk("t4_data", oreq.data, 64'hDEAD_BEEF_CAFE_BABE);
        chk("t4_strobe", oreq.strobe, 8'h0F);
        chk("t4_last", {iresps[0].ready, iresps[0].last}, 2'b11);
        step();
        ireqs[0] = '0;
        @(negedge clk);
        chk("t4_busy_drop", busy, 0);

        // abandon: port 1 drops valid after beat 1, waiting port 0 takes over
        step();
        ireqs[1] = '{valid: 1, is_write: 0, size: 3, addr: 32'h400, strobe: 8'hFF, data: 0, len: 7, burst: 1};
        @(negedge clk);
        @(negedge clk);
        chk("t5_grant1", grant_idx, 1);
        step();
        ireqs[0] = '{valid: 1, is_write: 0, size: 3, addr: 32'h500, strobe: 8'hFF, data: 0, len: 7, burst: 1};
        @(negedge clk);
        chk("t5_beat1", iresps[1].ready, 1);
        chk("t5_noleak", iresps[0], 0);
        step();
        ireqs[1].valid = 0;
        @(negedge clk);
        @(negedge clk);
        chk("t5_idle", busy, 0);
        chk("t5_ovalid", oreq.valid, 0);
        @(negedge clk);
        chk("t5_busy0", busy, 1);
        chk("t5_grant0", grant_idx, 0);
        wait_last(0);
        chk("t5_beats", nb, 8);
        step();
        ireqs[0] = '0;
        ireqs[1] = '0;
        @(negedge clk);

        // reset mid-burst
        step();
        ireqs[1] = '{valid: 1, is_write: 0, size: 3, addr: 32'h600, strobe: 8'hFF, data: 0, len: 7, burst: 1};
        @(negedge clk);
        @(negedge clk);
        chk("t6_grant1", grant_idx, 1);
        step();
        reset = 1;
        step();
        reset = 0;
        @(negedge clk);
        chk("t6_busy", busy, 0);
        chk("t6_grant", grant_idx, 0);
        chk("t6_oreq", oreq, 0);
        chk("t6_resp0", iresps[0], 0);
        chk("t6_resp1", iresps[1], 0);
        step();
        ireqs[1] = '0;
        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end
endmodule

// File: doc/cbus_arbiter.md
Name: cbus_arbiter

Overview:
- N-to-1 arbiter upstream of the CBus-to-SRAM bridge.
- Collects cbus_req_t requests from NUM_REQ masters (icache, dcache, uncached path) and forwards exactly one transaction at a time on the single downstream CBus.
- Routes the bridge's cbus_resp_t back to the granted master only.
- Holds the grant for the whole burst, i.e. until the beat with ready && last.

Parameters:
- NUM_REQ, 2, number of upstream requesters; legal range 2..4.
- IDX_W, $clog2(NUM_REQ), width of the grant index; derived, not overridden.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- ireqs  input  NUM_REQ x cbus_req_t  upstream requests; fields valid, is_write, size, addr, strobe, data, len, burst.
- iresps  output  NUM_REQ x cbus_resp_t  upstream responses; fields ready, last, data.
- oreq  output  cbus_req_t  request to the CBus-to-SRAM bridge.
- oresp  input  cbus_resp_t  response from the bridge.
- busy  output  1  high while a grant is held (state BUSY).
- grant_idx  output  IDX_W  index of the current or most recent grant.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Reset values: state IDLE, busy 0, grant_idx 0, rr pointer 0. oreq is all zeros (valid 0). Every iresps[i] is all zeros.
- States: IDLE, BUSY.
- IDLE:
  - oreq is driven all-zero; all iresps are zero.
  - If any ireqs[i].valid, pick a winner: lowest index by default, see Optional Feature. Register it into grant_idx and move to BUSY on the next edge.
  - Arbitration adds exactly 1 cycle of latency: first downstream valid appears the cycle after the request is seen.
- BUSY:
  - oreq = ireqs[grant_idx], combinational pass-through of all fields.
  - iresps[grant_idx] = oresp. Every other iresps[j] stays all-zero, so ready 0 and no data leaks to losers.
- BUSY -> IDLE on either of:
  - (a) oresp.ready && oresp.last in the same cycle (normal completion, including single-beat FIXED bursts);
  - (b) ireqs[grant_idx].valid == 0 (requester abandoned; protocol violation, arbiter recovers).
  - After (a) or (b) there is a mandatory 1-cycle IDLE before the next grant. The downstream bridge therefore always sees valid low for at least one cycle between transactions, so its counter/state can return to INIT.
- Requests arriving in BUSY from non-granted masters wait; they are not dropped. Requesters must hold valid and all fields stable until they see ready && last.
- Simultaneous completion and new request from the same master: that master re-arbitrates normally after the IDLE cycle.
- grant_idx holds its value in IDLE, for debug and for the rr pointer.
- Reset asserted in BUSY: next cycle IDLE with all outputs zero. The in-flight burst is abandoned; the bench must also reset the bridge.
- No combinational path from oresp to oreq. The only oresp -> iresps path is pure muxing.

Optional Feature:
- Macro CBUS_ARB_RR_EN.
- Defined: round-robin arbitration.
  - Register rr_ptr (IDX_W bits, reset 0) is updated to grant_idx+1 (mod NUM_REQ) when a grant is issued.
  - The winner is the first valid requester scanning from rr_ptr upward with wrap-around.
- Undefined: fixed priority, lowest index wins; rr_ptr is not instantiated.
- Latency and handshake are identical either way.

Test Plan:
- Single requester:
  - Stimulus: ireqs[1] INCR read, len=3, addr 0x80000000, bridge DELAY set to 0.
  - Required: grant_idx=1 one cycle later; oreq mirrors ireqs[1]; iresps[1] sees 4 ready beats, last on the 4th; iresps[0] all zero; busy drops the cycle after last.
- Contention, fixed priority (no macro):
  - Stimulus: ireqs[0] and ireqs[1] both valid in cycle 0.
  - Required: port 0 served first; port 1 granted exactly 2 cycles after port 0's ready && last (1 transition cycle + 1 arbitration cycle).
- Contention, round-robin (CBUS_ARB_RR_EN defined):
  - Stimulus: ports 0 and 1 continuously issue FIXED 1-beat writes, 6 transactions total.
  - Required: grant sequence 0,1,0,1,0,1.
- Write pass-through:
  - Stimulus: port 0 FIXED write, addr 0x80000010, data 0xDEADBEEF_CAFEBABE, strobe 0x0F.
  - Required: oreq fields bit-identical to ireqs[0] while busy; busy drops the cycle after ready && last.
- Abandon:
  - Stimulus: granted port 1 drops valid mid-burst (after beat 1 of len=7).
  - Required: state IDLE next cycle, oreq.valid 0; waiting port 0 granted the following cycle.
- Reset mid-burst:
  - Stimulus: assert reset for 1 cycle during BUSY.
  - Required: next cycle busy=0, grant_idx=0, oreq=0, all iresps=0.
